// File: rtl/seq_signed_divider_pkg.sv
// Shared constants and types for the sequential signed divider.
//   DW, DW_2   : operand widths (divisor/quotient/remainder, dividend)
//   ONE, ZERO  : single-bit constants for quotient bit insertion
//   CNT_W      : width of the restoring-step counter
//   state_t    : FSM encoding (IDLE, CHECK, SHIFT, FIX, DONE)
//   Q_MAX/Q_MIN: largest positive / most negative DW-bit quotient
package seq_signed_divider_pkg;

  localparam int DW    = 4;
  localparam int DW_2  = 2 * DW;
  localparam logic ONE  = 1'b1;
  localparam logic ZERO = 1'b0;

  localparam int CNT_W = $clog2(DW);

  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t CHECK = 3'd1;
  localparam state_t SHIFT = 3'd2;
  localparam state_t FIX   = 3'd3;
  localparam state_t DONE  = 3'd4;

  localparam logic [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

endpackage

// File: rtl/seq_signed_divider_div_control.sv
// Sequencer for the signed divider: FSM, restoring-step counter, busy/done.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request, only honoured in IDLE
//   chk_err   : divide-by-zero / overflow detected while in CHECK
//   state     : current FSM state, drives the datapath
//   busy      : high in CHECK, SHIFT and FIX
//   done      : high for the single DONE cycle
module div_control
  import seq_signed_divider_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   chk_err,
  output state_t state,
  output logic   busy,
  output logic   done
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE:  if (start) state_next = CHECK;
      CHECK: begin
        if (chk_err) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
          count_next = CNT_W'(DW - 1);
        end
      end
      SHIFT: begin
        // The step at count==0 is the last of DW steps.
        if (count_reg == '0) state_next = FIX;
        else                 count_next = count_reg - CNT_W'(1);
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  assign state = state_reg;
  assign busy  = (state_reg == CHECK) || (state_reg == SHIFT) || (state_reg == FIX);
  assign done  = (state_reg == DONE);

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider: DW_2-bit dividend / DW-bit divisor,
// one quotient bit per clock, quotient truncated toward zero, remainder
// carrying the dividend's sign.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request, sampled in IDLE; operands latched on that edge
//   dividend   : DW_2-bit two's-complement dividend
//   divisor    : DW-bit two's-complement divisor
//   busy       : operation in progress
//   done       : one-cycle completion pulse; results valid from here on
//   err        : divide-by-zero or quotient overflow
//   sign       : quotient sign
//   quotient   : DW-bit two's-complement quotient
//   remainder  : DW-bit two's-complement remainder
// Build option: define DIV_SATURATE_EN to saturate the quotient on err
// (otherwise it reads 0).
module seq_signed_divider
  import seq_signed_divider_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW_2-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            sign,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder
);

`ifdef DIV_SATURATE_EN
  localparam logic [DW-1:0] ERR_Q_POS = Q_MAX;
  localparam logic [DW-1:0] ERR_Q_NEG = Q_MIN;
`else
  localparam logic [DW-1:0] ERR_Q_POS = '0;
  localparam logic [DW-1:0] ERR_Q_NEG = '0;
`endif

  state_t state;
  logic   chk_err;

  logic [DW_2-1:0] dividend_reg;
  logic [DW-1:0]   divisor_reg;
  logic            dvd_neg_reg, dvs_neg_reg;
  logic [DW:0]     dvs_mag_reg;
  logic [DW-1:0]   rem_reg;   // partial remainder, always < |divisor|
  logic [DW-1:0]   q_reg;     // low dividend bits shifting out, quotient bits in
  logic            err_reg, sign_reg;
  logic [DW-1:0]   quotient_reg, remainder_reg;

  div_control u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .chk_err (chk_err),
    .state   (state),
    .busy    (busy),
    .done    (done)
  );

  // One extra bit on each magnitude so -2^(DW_2-1) and -2^(DW-1) fit.
  logic [DW_2:0] dvd_ext, dvd_mag;
  logic [DW:0]   dvs_ext, dvs_mag;

  assign dvd_ext = {dividend_reg[DW_2-1], dividend_reg};
  assign dvd_mag = dividend_reg[DW_2-1] ? -dvd_ext : dvd_ext;
  assign dvs_ext = {divisor_reg[DW-1], divisor_reg};
  assign dvs_mag = divisor_reg[DW-1] ? -dvs_ext : dvs_ext;

  // If the upper half already reaches |divisor| the unsigned quotient needs
  // more than DW bits.
  assign chk_err = (divisor_reg == '0) || (dvd_mag[DW_2:DW] >= dvs_mag);

  // Restoring step: shift one dividend bit into the partial remainder and
  // trial-subtract; the extra top bit of the difference is its borrow.
  logic [DW:0]   step_shift;
  logic [DW+1:0] step_diff;

  assign step_shift = {rem_reg, q_reg[DW-1]};
  assign step_diff  = {1'b0, step_shift} - {1'b0, dvs_mag_reg};

  // Negative quotients may reach one further than positive ones.
  logic q_neg, fix_ovf;

  assign q_neg   = dvd_neg_reg ^ dvs_neg_reg;
  assign fix_ovf = q_neg ? (q_reg > Q_MIN) : (q_reg > Q_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      dvd_neg_reg   <= 1'b0;
      dvs_neg_reg   <= 1'b0;
      dvs_mag_reg   <= '0;
      rem_reg       <= '0;
      q_reg         <= '0;
      err_reg       <= 1'b0;
      sign_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
          end
        end
        CHECK: begin
          dvd_neg_reg <= dividend_reg[DW_2-1];
          dvs_neg_reg <= divisor_reg[DW-1];
          dvs_mag_reg <= dvs_mag;
          rem_reg     <= dvd_mag[DW_2-1:DW];
          q_reg       <= dvd_mag[DW-1:0];
          if (chk_err) begin
            err_reg       <= 1'b1;
            sign_reg      <= dividend_reg[DW_2-1] ^ divisor_reg[DW-1];
            quotient_reg  <= (dividend_reg[DW_2-1] ^ divisor_reg[DW-1]) ? ERR_Q_NEG : ERR_Q_POS;
            remainder_reg <= '0;
          end
        end
        SHIFT: begin
          if (!step_diff[DW+1]) begin
            rem_reg <= step_diff[DW-1:0];
            q_reg   <= {q_reg[DW-2:0], ONE};
          end else begin
            rem_reg <= step_shift[DW-1:0];
            q_reg   <= {q_reg[DW-2:0], ZERO};
          end
        end
        FIX: begin
          if (fix_ovf) begin
            err_reg       <= 1'b1;
            sign_reg      <= q_neg;
            quotient_reg  <= q_neg ? ERR_Q_NEG : ERR_Q_POS;
            remainder_reg <= '0;
          end else begin
            err_reg       <= 1'b0;
            sign_reg      <= q_neg && (q_reg != '0);
            quotient_reg  <= q_neg ? -q_reg : q_reg;
            remainder_reg <= dvd_neg_reg ? -rem_reg : rem_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign err       = err_reg;
  assign sign      = sign_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: tb/tb_seq_signed_divider.sv
module tb_seq_signed_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, err, sign;
  logic [3:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

`ifdef DIV_SATURATE_EN
  localparam logic [3:0] QE_POS = 4'h7;
  localparam logic [3:0] QE_NEG = 4'h8;
`else
  localparam logic [3:0] QE_POS = 4'h0;
  localparam logic [3:0] QE_NEG = 4'h0;
`endif

  seq_signed_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sign      (sign),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [3:0] r;
    logic       s;
    logic       e;
    int         lat;   // edges from acceptance edge to done-visible
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done; leaves the DUT back in IDLE.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int idx, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", idx, 32'(busy), 32'd1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic done_clears(input int idx);
    @(posedge clk);
    #1;
    check("done_one_cycle", idx, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int dones;

    //            dvd    dvs    q       r      s     e     lat
    vecs[0]  = '{8'hF9, 4'hF, 4'h7,   4'h0, 1'b0, 1'b0, 6};  // -7 / -1
    vecs[1]  = '{8'hE4, 4'h7, 4'hC,   4'h0, 1'b1, 1'b0, 6};  // -28 / 7
    vecs[2]  = '{8'hE9, 4'h5, 4'hC,   4'hD, 1'b1, 1'b0, 6};  // -23 / 5
    vecs[3]  = '{8'h17, 4'h5, 4'h4,   4'h3, 1'b0, 1'b0, 6};  // 23 / 5
    vecs[4]  = '{8'h14, 4'h0, QE_POS, 4'h0, 1'b0, 1'b1, 1};  // 20 / 0
    vecs[5]  = '{8'h40, 4'h1, QE_POS, 4'h0, 1'b0, 1'b1, 1};  // 64 / 1, early overflow
    vecs[6]  = '{8'h08, 4'h1, QE_POS, 4'h0, 1'b0, 1'b1, 6};  // 8 / 1, late overflow
    vecs[7]  = '{8'hF8, 4'h1, 4'h8,   4'h0, 1'b1, 1'b0, 6};  // -8 / 1 = -8 legal
    vecs[8]  = '{8'hF7, 4'h1, QE_NEG, 4'h0, 1'b1, 1'b1, 6};  // -9 / 1, late overflow
    vecs[9]  = '{8'h80, 4'h8, QE_POS, 4'h0, 1'b0, 1'b1, 1};  // -128 / -8
    vecs[10] = '{8'h38, 4'h8, 4'h9,   4'h0, 1'b1, 1'b0, 6};  // 56 / -8 = -7
    vecs[11] = '{8'hFF, 4'h2, 4'h0,   4'hF, 1'b0, 1'b0, 6};  // -1 / 2 = 0 r -1
    vecs[12] = '{8'h07, 4'hE, 4'hD,   4'h1, 1'b1, 1'b0, 6};  // 7 / -2 = -3 r 1

    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 0, 32'(busy), 32'd0);
    check("reset_done", 0, 32'(done), 32'd0);
    check("reset_err", 0, 32'(err), 32'd0);
    check("reset_sign", 0, 32'(sign), 32'd0);
    check("reset_q", 0, 32'(quotient), 32'd0);
    check("reset_r", 0, 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, i, lat);
      $display("op %0d: %0d / %0d -> q=%0d r=%0d sign=%0b err=%0b latency=%0d",
               i, $signed(vecs[i].dvd), $signed(vecs[i].dvs),
               $signed(quotient), $signed(remainder), sign, err, lat);
      check("latency", i, 32'(lat), 32'(vecs[i].lat));
      check("quotient", i, 32'(quotient), 32'(vecs[i].q));
      check("remainder", i, 32'(remainder), 32'(vecs[i].r));
      check("sign", i, 32'(sign), 32'(vecs[i].s));
      check("err", i, 32'(err), 32'(vecs[i].e));
      check("busy_at_done", i, 32'(busy), 32'd0);
      done_clears(i);
    end

    // Extra start two cycles into an operation must be ignored.
    @(negedge clk);
    dividend = 8'h17;
    divisor  = 4'h5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    lat   = -1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 2) begin
        dividend = 8'h14;
        divisor  = 4'h0;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (lat < 0) lat = i;
        check("ignored_start_q", 100, 32'(quotient), 32'h4);
        check("ignored_start_r", 100, 32'(remainder), 32'h3);
        check("ignored_start_err", 100, 32'(err), 32'd0);
      end
    end
    $display("op ignored-start: 23 / 5 with stray start, dones=%0d latency=%0d", dones, lat);
    check("ignored_start_dones", 100, 32'(dones), 32'd1);
    check("ignored_start_latency", 100, 32'(lat), 32'd6);

    // start held high re-triggers once back in IDLE.
    @(negedge clk);
    dividend = 8'hE9;
    divisor  = 4'h5;
    start    = 1'b1;
    dones    = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    $display("op held-start: -23 / 5 over 15 edges, dones=%0d", dones);
    check("held_start_dones", 101, 32'(dones), 32'd2);
    check("held_start_q", 101, 32'(quotient), 32'hC);

    // Reset during SHIFT aborts the operation with no done.
    @(negedge clk);
    dividend = 8'h17;
    divisor  = 4'h5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midop_rst_busy", 102, 32'(busy), 32'd0);
    check("midop_rst_done", 102, 32'(done), 32'd0);
    check("midop_rst_err", 102, 32'(err), 32'd0);
    check("midop_rst_sign", 102, 32'(sign), 32'd0);
    check("midop_rst_q", 102, 32'(quotient), 32'd0);
    check("midop_rst_r", 102, 32'(remainder), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    $display("op reset-abort: activity after reset=%0d", dones);
    check("midop_rst_no_done", 102, 32'(dones), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
